// File: rtl/ram_arb_mp.sv
// Shared 32-bit data RAM behind an N-port arbiter.
// One access per cycle: byte-enabled write or one-cycle-latency read.
// Arbitration is fixed priority or round-robin. Out-of-range accesses are
// flagged, and cycles with contending requests are counted.
module ram_arb_mp #(
  parameter int N_PORTS   = 3,
  parameter int DEPTH_LG2 = 5,
  parameter int ARB_RR    = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   i_req,
  input  logic [4*N_PORTS-1:0] i_wen,
  input  logic [32*N_PORTS-1:0] i_addr,
  input  logic [32*N_PORTS-1:0] i_wdata,
  output logic [N_PORTS-1:0]   o_gnt,
  output logic [31:0]          o_rdata,
  output logic [N_PORTS-1:0]   o_rvalid,
  output logic [N_PORTS-1:0]   o_err,
  output logic [CNT_W-1:0]     o_conflict
);

  localparam int          DEPTH = 1 << DEPTH_LG2;
  localparam int          PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned NP    = N_PORTS;

  logic [31:0]          mem [0:DEPTH-1];
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [N_PORTS-1:0]   gnt;
  int unsigned          cand;

  logic [3:0]           sel_wen;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic [DEPTH_LG2-1:0] idx;
  logic                 in_range;
  logic                 is_write;

  // Grant selection: fixed priority or round-robin search from ptr; nothing during reset
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    if (!rst) begin
      if (ARB_RR == 0) begin
        for (int unsigned p = 0; p < NP; p++) begin
          if (i_req[p] && !gnt_any) begin
            gnt[p]  = 1'b1;
            gnt_idx = PTR_W'(p);
            gnt_any = 1'b1;
          end
        end
      end else begin
        for (int unsigned k = 0; k < NP; k++) begin
          // Wrap the search index without a modulo operator
          cand = k + {{(32-PTR_W){1'b0}}, ptr};
          if (cand >= NP) cand = cand - NP;
          if (i_req[cand] && !gnt_any) begin
            gnt[cand] = 1'b1;
            gnt_idx   = PTR_W'(cand);
            gnt_any   = 1'b1;
          end
        end
      end
    end
  end

  assign o_gnt = gnt;

  // Mux the granted port's access fields and decode address validity
  always_comb begin
    sel_wen   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (gnt[p]) begin
        sel_wen   = i_wen[4*p +: 4];
        sel_addr  = i_addr[32*p +: 32];
        sel_wdata = i_wdata[32*p +: 32];
      end
    end
    idx      = sel_addr[DEPTH_LG2+1:2];
    in_range = (sel_addr[31:DEPTH_LG2+2] == '0) && (sel_addr[1:0] == 2'b00);
    is_write = (sel_wen != 4'b0000);
  end

  // RAM byte-lane writes; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (gnt_any && in_range && is_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_wen[b]) mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

  // Read data, per-port completion/error pulses and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rvalid <= '0;
      o_err    <= '0;
      o_rdata  <= '0;
      ptr      <= '0;
    end else begin
      o_rvalid <= '0;
      o_err    <= '0;
      if (gnt_any) begin
        if (!in_range) begin
          o_err <= gnt;
        end else if (!is_write) begin
          o_rvalid <= gnt;
          o_rdata  <= mem[idx];
        end
        if (32'(gnt_idx) == NP - 1) ptr <= '0;
        else                        ptr <= gnt_idx + PTR_W'(1);
      end
    end
  end

  // Saturating count of cycles with two or more active requests
  always_ff @(posedge clk) begin
    if (rst) begin
      o_conflict <= '0;
    end else if (($countones(i_req) >= 2) && (o_conflict != '1)) begin
      o_conflict <= o_conflict + CNT_W'(1);
    end
  end

endmodule
